cache_axi_arbiter: RTL

Shares one AXI3 master port between the I-cache line-refill reader, the D-cache line-refill reader and the D-cache dirty-line writeback writer. One read burst and one write burst may be outstanding at a time. D-cache reads have priority, with a starvation guard for I-cache. Read/write line-address hazards are held off. The block sits between the cache controllers and the SoC AXI crossbar and replaces single-word SRAM-like bridging for cached traffic.

---
 rtl/cache_axi_pkg.sv | 19 +
 rtl/cache_axi_wr_ctrl.sv | 91 +++++++++
 rtl/cache_axi_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/cache_axi_pkg.sv
// rtl/cache_axi_pkg.sv - shared types and AXI constants for the cache AXI arbiter
package cache_axi_pkg;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [3:0] ID_ICACHE      = 4'd0;
  localparam logic [3:0] ID_DCACHE      = 4'd1;

  // Clears the byte-within-line bits; off is log2 of the line size in bytes.
  function automatic logic [31:0] line_align(input logic [31:0] addr, input int unsigned off);
    logic [31:0] mask;
    mask = ~((32'd1 << off) - 32'd1);
    return addr & mask;
  endfunction

endpackage

// File: rtl/cache_axi_wr_ctrl.sv
// rtl/cache_axi_wr_ctrl.sv - D-cache writeback burst engine driving the AXI AW/W/B channels
module cache_axi_wr_ctrl
  import cache_axi_pkg::*;
#(
  parameter int LINE_WORDS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dc_wr_req,
  input  logic [31:0] wr_line,
  input  logic [31:0] dc_wr_data,
  output logic        dc_wr_gnt,
  output logic        dc_wr_beat,
  output logic        dc_wr_done,
  output logic        wr_busy,
  output logic [31:0] wr_line_q,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  localparam int BW = $clog2(LINE_WORDS);

  wr_state_t     state, state_nxt;
  logic [BW-1:0] beat;
  logic          last_beat;

  assign last_beat = (beat == BW'(LINE_WORDS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= W_IDLE;
      beat      <= '0;
      wr_line_q <= '0;
    end else begin
      state <= state_nxt;
      if (dc_wr_gnt) wr_line_q <= wr_line;
      // Power-of-two burst length lets the counter wrap back to 0 on its own.
      if (dc_wr_beat) beat <= beat + BW'(1);
    end
  end

  always_comb begin
    state_nxt  = state;
    dc_wr_gnt  = 1'b0;
    dc_wr_beat = 1'b0;
    dc_wr_done = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    case (state)
      W_IDLE: begin
        if (dc_wr_req) begin
          dc_wr_gnt = 1'b1;
          state_nxt = W_ADDR;
        end
      end
      W_ADDR: begin
        awvalid = 1'b1;
        if (awready) state_nxt = W_DATA;
      end
      W_DATA: begin
        wvalid = 1'b1;
        if (wready) begin
          dc_wr_beat = 1'b1;
          if (last_beat) state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          dc_wr_done = 1'b1;
          state_nxt  = W_IDLE;
        end
      end
      default: state_nxt = W_IDLE;
    endcase
  end

  assign wlast   = (state == W_DATA) && last_beat;
  assign wdata   = dc_wr_data;
  assign wstrb   = 4'hF;
  assign wr_busy = (state != W_IDLE);

endmodule

// File: rtl/cache_axi_arbiter.sv
// rtl/cache_axi_arbiter.sv - shares one AXI3 master between I-cache refill, D-cache refill and writeback
module cache_axi_arbiter
  import cache_axi_pkg::*;
#(
  parameter int LINE_WORDS = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ic_rd_req,
  input  logic [31:0] ic_rd_addr,
  output logic        ic_rd_gnt,
  output logic        ic_rd_valid,
  input  logic        dc_rd_req,
  input  logic [31:0] dc_rd_addr,
  output logic        dc_rd_gnt,
  output logic        dc_rd_valid,
  output logic        rd_last,
  output logic [31:0] rd_data,
  input  logic        dc_wr_req,
  input  logic [31:0] dc_wr_addr,
  output logic        dc_wr_gnt,
  input  logic [31:0] dc_wr_data,
  output logic        dc_wr_beat,
  output logic        dc_wr_done,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam int OFF = $clog2(LINE_WORDS * 4);
  localparam int SW  = $clog2(STARVE_MAX + 1);

  rd_state_t   rd_state, rd_state_nxt;
  logic        rd_owner_dc;
  logic [31:0] araddr_q;
  logic [SW-1:0] starve;
  logic [31:0] ic_line, dc_line, wr_req_line, wr_line_q;
  logic        wr_busy, ic_haz, dc_haz, ic_ok, dc_ok, ic_win, dc_win;
  logic        unused_ok;

  assign ic_line     = line_align(ic_rd_addr, OFF);
  assign dc_line     = line_align(dc_rd_addr, OFF);
  assign wr_req_line = line_align(dc_wr_addr, OFF);

  // A refill must not overtake a writeback of the same line, including one granted this cycle.
  assign ic_haz = (wr_busy && ic_line == wr_line_q) || (dc_wr_gnt && ic_line == wr_req_line);
  assign dc_haz = (wr_busy && dc_line == wr_line_q) || (dc_wr_gnt && dc_line == wr_req_line);
  assign ic_ok  = ic_rd_req && !ic_haz;
  assign dc_ok  = dc_rd_req && !dc_haz;

  always_comb begin
    rd_state_nxt = rd_state;
    ic_win       = 1'b0;
    dc_win       = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    case (rd_state)
      R_IDLE: begin
        if (ic_ok && starve == SW'(STARVE_MAX)) ic_win = 1'b1;
        else if (dc_ok)                         dc_win = 1'b1;
        else if (ic_ok)                         ic_win = 1'b1;
        if (ic_win || dc_win) rd_state_nxt = R_ADDR;
      end
      R_ADDR: begin
        arvalid = 1'b1;
        if (arready) rd_state_nxt = R_DATA;
      end
      R_DATA: begin
        rready = 1'b1;
        if (rvalid && rlast) rd_state_nxt = R_IDLE;
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state    <= R_IDLE;
      rd_owner_dc <= 1'b0;
      araddr_q    <= '0;
      starve      <= '0;
    end else begin
      rd_state <= rd_state_nxt;
      if (ic_win) begin
        rd_owner_dc <= 1'b0;
        araddr_q    <= ic_line;
        starve      <= '0;
      end else if (dc_win) begin
        rd_owner_dc <= 1'b1;
        araddr_q    <= dc_line;
        if (ic_rd_req && starve != SW'(STARVE_MAX)) starve <= starve + SW'(1);
      end
    end
  end

  assign ic_rd_gnt   = ic_win;
  assign dc_rd_gnt   = dc_win;
  // Beats are steered by the latched owner; rid is not trusted for routing.
  assign ic_rd_valid = rready && rvalid && !rd_owner_dc;
  assign dc_rd_valid = rready && rvalid && rd_owner_dc;
  assign rd_last     = rready && rvalid && rlast;
  assign rd_data     = rdata;

  assign arid    = rd_owner_dc ? ID_DCACHE : ID_ICACHE;
  assign araddr  = araddr_q;
  assign arlen   = 8'(LINE_WORDS - 1);
  assign arsize  = AXI_SIZE_WORD;
  assign arburst = AXI_BURST_INCR;

  assign awid    = ID_DCACHE;
  assign wid     = ID_DCACHE;
  assign awaddr  = wr_line_q;
  assign awlen   = 8'(LINE_WORDS - 1);
  assign awsize  = AXI_SIZE_WORD;
  assign awburst = AXI_BURST_INCR;

  assign unused_ok = ^{rid, rresp, bid, bresp};

  cache_axi_wr_ctrl #(.LINE_WORDS(LINE_WORDS)) u_wr_ctrl (
    .clk        (clk),
    .reset      (reset),
    .dc_wr_req  (dc_wr_req),
    .wr_line    (wr_req_line),
    .dc_wr_data (dc_wr_data),
    .dc_wr_gnt  (dc_wr_gnt),
    .dc_wr_beat (dc_wr_beat),
    .dc_wr_done (dc_wr_done),
    .wr_busy    (wr_busy),
    .wr_line_q  (wr_line_q),
    .awvalid    (awvalid),
    .awready    (awready),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .wlast      (wlast),
    .wvalid     (wvalid),
    .wready     (wready),
    .bvalid     (bvalid),
    .bready     (bready)
  );

endmodule
